// File: rtl/joycon_scan_ctrl_if.sv
// joycon_scan_ctrl_if: CPU memory-mapped I/O bus seen by the joypad controller.
// cpu_addr     16  bus address
// cpu_data_in   8  write data (only bit 0 is meaningful to the pads)
// cpu_write_en  1  one-cycle write strobe
// cpu_read_en   1  one-cycle read strobe
// cpu_data_out  8  read data returned by the controller
// master = CPU side, slave = controller side.
interface joycon_scan_ctrl_if;
  logic [15:0] cpu_addr;
  logic [7:0] cpu_data_in;
  logic cpu_write_en;
  logic cpu_read_en;
  logic [7:0] cpu_data_out;
  modport master(output cpu_addr, cpu_data_in, cpu_write_en, cpu_read_en, input cpu_data_out);
  modport slave(input cpu_addr, cpu_data_in, cpu_write_en, cpu_read_en, output cpu_data_out);
endinterface

// File: rtl/joycon_scan_ctrl.sv
// joycon_scan_ctrl: periodic two-port NES pad scanner with $4016/$4017 CPU read protocol.
// clk, rst          clock; asynchronous active-low reset
// bus (slave)       CPU address/data/strobes, registered read data
// pad_latch/pad_clk registered pad control lines, never high together
// pad_data[1:0]     active-low serial pad data ([0]=port 1, [1]=port 2)
// pad1/pad2_state   committed button bytes, active-high
// scan_done         one-cycle pulse after each COMMIT
// Optional: JOYCON_DEBOUNCE_EN commits a port only when two consecutive scans agree.
module joycon_scan_ctrl #(
  parameter int CLK_DIV = 6,
  parameter int SCAN_PERIOD = 50000,
  parameter logic [15:0] P1_ADDR = 16'h4016,
  parameter logic [15:0] P2_ADDR = 16'h4017
) (
  input logic clk,
  input logic rst,
  joycon_scan_ctrl_if.slave bus,
  output logic pad_latch,
  output logic pad_clk,
  input logic [1:0] pad_data,
  output logic [7:0] pad1_state,
  output logic [7:0] pad2_state,
  output logic scan_done
);
  localparam int MAXC = SCAN_PERIOD > 2 * CLK_DIV ? SCAN_PERIOD : 2 * CLK_DIV;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic [2:0] {IDLE, LATCH, WAIT0, CLK_HI, CLK_LO, COMMIT} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt, lim;
  logic [2:0] nbit;
  logic cnt_end, smp;
  logic [1:0] sync0, sync1;
  logic [7:0] raw1, raw2, sh1, sh2;
  logic strobe, rd1, rd2, wr1;
  logic unused_data;
`ifdef JOYCON_DEBOUNCE_EN
  logic [7:0] prev1, prev2;
  logic prev_ok;
`endif
  assign unused_data = ^bus.cpu_data_in[7:1];
  // nbit counts bits already captured, so the CLK_LO that sees 7 takes the last one.
  always_comb begin
    lim = state == IDLE ? CW'(SCAN_PERIOD - 1) : state == LATCH ? CW'(2 * CLK_DIV - 1) : CW'(CLK_DIV - 1);
    cnt_end = cnt == lim;
    smp = cnt_end && (state == WAIT0 || state == CLK_LO);
    nxt = state == COMMIT ? IDLE : !cnt_end ? state : state == IDLE ? LATCH :
          state == LATCH ? WAIT0 : state == WAIT0 ? CLK_HI : state == CLK_HI ? CLK_LO :
          nbit == 3'd7 ? COMMIT : CLK_HI;
    rd1 = bus.cpu_read_en && bus.cpu_addr == P1_ADDR;
    rd2 = bus.cpu_read_en && bus.cpu_addr == P2_ADDR;
    wr1 = bus.cpu_write_en && bus.cpu_addr == P1_ADDR;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      nbit <= '0;
    end else begin
      state <= nxt;
      cnt <= nxt != state ? '0 : cnt + 1'b1;
      nbit <= state == LATCH ? 3'd0 : smp ? nbit + 3'd1 : nbit;
    end
  // Bits arrive A first; shifting in at the MSB leaves A in bit 0 after eight samples.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync0 <= '0;
      sync1 <= '0;
      raw1 <= '0;
      raw2 <= '0;
      pad_latch <= 1'b0;
      pad_clk <= 1'b0;
      scan_done <= 1'b0;
      pad1_state <= '0;
      pad2_state <= '0;
`ifdef JOYCON_DEBOUNCE_EN
      prev1 <= '0;
      prev2 <= '0;
      prev_ok <= 1'b0;
`endif
    end else begin
      sync0 <= pad_data;
      sync1 <= sync0;
      if (smp) begin
        raw1 <= {~sync1[0], raw1[7:1]};
        raw2 <= {~sync1[1], raw2[7:1]};
      end
      pad_latch <= nxt == LATCH;
      pad_clk <= nxt == CLK_HI;
      scan_done <= state == COMMIT;
      if (state == COMMIT) begin
`ifdef JOYCON_DEBOUNCE_EN
        if (prev_ok && raw1 == prev1) pad1_state <= raw1;
        if (prev_ok && raw2 == prev2) pad2_state <= raw2;
        prev1 <= raw1;
        prev2 <= raw2;
        prev_ok <= 1'b1;
`else
        pad1_state <= raw1;
        pad2_state <= raw2;
`endif
      end
    end
  // Shift registers fill with 1s so reads past the eighth bit return 1.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      strobe <= 1'b0;
      sh1 <= '0;
      sh2 <= '0;
      bus.cpu_data_out <= '0;
    end else begin
      if (wr1) strobe <= bus.cpu_data_in[0];
      sh1 <= strobe ? pad1_state : rd1 && !wr1 ? {1'b1, sh1[7:1]} : sh1;
      sh2 <= strobe ? pad2_state : rd2 ? {1'b1, sh2[7:1]} : sh2;
      bus.cpu_data_out <= rd1 ? {7'b0, sh1[0]} : rd2 ? {7'b0, sh2[0]} : bus.cpu_data_out;
    end
endmodule

// File: tb/tb_joycon_scan_ctrl.sv
// tb_joycon_scan_ctrl: randomized bench with a cycle-level behavioural model of scan timing and CPU reads.
module tb_joycon_scan_ctrl;
  localparam int CD = 3;
  localparam int SP = 20;
  localparam int PER = SP + 17 * CD + 1;
  localparam logic [15:0] A1 = 16'h4016;
  localparam logic [15:0] A2 = 16'h4017;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pad_latch, pad_clk, scan_done;
  logic [1:0] pad_data;
  logic [7:0] pad1_state, pad2_state;
  joycon_scan_ctrl_if bus();
  joycon_scan_ctrl #(.CLK_DIV(CD), .SCAN_PERIOD(SP)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .pad_latch(pad_latch), .pad_clk(pad_clk),
    .pad_data(pad_data), .pad1_state(pad1_state), .pad2_state(pad2_state), .scan_done(scan_done)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Serial pad: parallel load on latch, advance one button per rising clock, active-low output.
  logic [7:0] btn1 = 8'h00, btn2 = 8'h00, pl1 = 8'h00, pl2 = 8'h00;
  logic [3:0] pidx = 4'd8;
  always @(posedge pad_latch or posedge pad_clk)
    if (pad_latch) begin
      pidx <= 4'd0;
      pl1 <= btn1;
      pl2 <= btn2;
    end else if (pidx < 4'd8) pidx <= pidx + 4'd1;
  assign pad_data[0] = pidx < 4'd8 ? ~pl1[pidx[2:0]] : 1'b0;
  assign pad_data[1] = pidx < 4'd8 ? ~pl2[pidx[2:0]] : 1'b0;
  // Model: n = clock edges since reset release, p = position within the scan period;
  // each CPU port is a snapshot byte plus a read index.
  int n = 0, p = 0, idx1 = 0, idx2 = 0;
  logic [7:0] st1 = 0, st2 = 0, sb1 = 0, sb2 = 0, snap1 = 0, snap2 = 0, dout_m = 0;
  logic strobe_m = 0, done_m = 0, m_r1, m_r2, m_w1;
`ifdef JOYCON_DEBOUNCE_EN
  logic [7:0] pv1 = 0, pv2 = 0;
  logic pv_ok = 0;
`endif
  function automatic logic bitv(input logic [7:0] s, input int i);
    return i < 8 ? s[i] : 1'b1;
  endfunction
  always @(posedge clk) begin
    if (!rst) begin
      n = 0; p = 0; st1 = 0; st2 = 0; snap1 = 0; snap2 = 0; idx1 = 0; idx2 = 0;
      strobe_m = 0; dout_m = 0; done_m = 0;
`ifdef JOYCON_DEBOUNCE_EN
      pv_ok = 0;
`endif
    end else begin
      m_r1 = bus.cpu_read_en && bus.cpu_addr == A1;
      m_r2 = bus.cpu_read_en && bus.cpu_addr == A2;
      m_w1 = bus.cpu_write_en && bus.cpu_addr == A1;
      if (m_r1) dout_m = {7'b0, bitv(snap1, idx1)};
      else if (m_r2) dout_m = {7'b0, bitv(snap2, idx2)};
      if (strobe_m) begin
        snap1 = st1; snap2 = st2; idx1 = 0; idx2 = 0;
      end else begin
        if (m_r1 && !m_w1 && idx1 < 8) idx1++;
        if (m_r2 && idx2 < 8) idx2++;
      end
      if (m_w1) strobe_m = bus.cpu_data_in[0];
      n++;
      p = n % PER;
      if (p == SP) begin sb1 = btn1; sb2 = btn2; end
      done_m = p == 0;
      if (done_m) begin
`ifdef JOYCON_DEBOUNCE_EN
        if (pv_ok && sb1 == pv1) st1 = sb1;
        if (pv_ok && sb2 == pv2) st2 = sb2;
        pv1 = sb1; pv2 = sb2; pv_ok = 1;
`else
        st1 = sb1; st2 = sb2;
`endif
      end
    end
    #1;
    chk("pad_latch", pad_latch, rst && p >= SP && p < SP + 2 * CD);
    chk("pad_clk", pad_clk, rst && p >= SP + 3 * CD && p < PER - 1 && ((p - SP - 3 * CD) % (2 * CD)) < CD);
    chk("scan_done", scan_done, done_m);
    chk("pad1_state", pad1_state, st1);
    chk("pad2_state", pad2_state, st2);
    chk("cpu_data_out", bus.cpu_data_out, dout_m);
  end
  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    bus.cpu_addr = a; bus.cpu_read_en = 1'b1;
    @(negedge clk);
    bus.cpu_read_en = 1'b0;
    d = bus.cpu_data_out;
  endtask
  task automatic wr(input logic [15:0] a, input logic b);
    bus.cpu_addr = a; bus.cpu_data_in = {7'h55, b}; bus.cpu_write_en = 1'b1;
    @(negedge clk);
    bus.cpu_write_en = 1'b0;
  endtask
  task automatic wait_done();
    int t = 0;
    do begin @(negedge clk); t++; end while (!scan_done && t < 200);
    chk("scan_done_wait", scan_done, 1'b1);
  endtask
  task automatic random_ops(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      int op = $urandom_range(0, 9);
      bus.cpu_read_en = op <= 4 || op == 7 || op == 8;
      bus.cpu_write_en = op == 5 || op == 6 || op == 8;
      bus.cpu_addr = op <= 2 || op == 5 || op == 8 ? A1 : op <= 4 || op == 6 ? A2 : 16'h4015;
      bus.cpu_data_in = 8'($urandom_range(0, 255));
      bus.cpu_data_in[0] = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 49) == 0) btn1 = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 49) == 0) btn2 = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    bus.cpu_read_en = 1'b0;
    bus.cpu_write_en = 1'b0;
  endtask
  logic [7:0] d;
  logic exp10 [10] = '{1, 0, 0, 1, 0, 0, 0, 0, 1, 1};
  logic exp6 [6] = '{0, 1, 0, 0, 0, 0};
  initial begin
    bus.cpu_addr = 16'h0; bus.cpu_data_in = 8'h0; bus.cpu_write_en = 1'b0; bus.cpu_read_en = 1'b0;
    btn1 = 8'h09; btn2 = 8'h80;
`ifdef JOYCON_DEBOUNCE_EN
    btn1 = 8'h01;
`endif
    repeat (3) @(negedge clk);
    chk("reset_pad1", pad1_state, 8'h00);
    chk("reset_dout", bus.cpu_data_out, 8'h00);
    rst = 1'b1;
`ifndef JOYCON_DEBOUNCE_EN
    begin
      int lat = 0, rises = 0, dn = 0;
      logic prev = 1'b0;
      for (int i = 0; i < PER; i++) begin
        @(negedge clk);
        lat += int'(pad_latch);
        if (pad_clk && !prev) rises++;
        prev = pad_clk;
        dn += int'(scan_done);
      end
      chk("latch_cycles", lat, 6);
      chk("clk_pulses", rises, 7);
      chk("done_pulses", dn, 1);
      chk("scan_pad1", pad1_state, 8'h09);
      chk("scan_pad2", pad2_state, 8'h80);
    end
    wr(A1, 1'b1);
    repeat (2) @(negedge clk);
    wr(A1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      rd(A1, d);
      chk("serial_read", d, {7'b0, exp10[i]});
    end
    wr(A1, 1'b1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rd(A1, d);
      chk("strobe_read", d, 8'h01);
    end
    wr(A1, 1'b0);
    rd(A1, d);
    chk("post_strobe_bit0", d, 8'h01);
    rd(A1, d);
    chk("post_strobe_bit1", d, 8'h00);
    btn1 = 8'hFF;
    begin
      int t = 0;
      while (pad1_state !== 8'hFF && t < 300) begin @(negedge clk); t++; end
      chk("commit_ff", pad1_state, 8'hFF);
    end
    for (int i = 0; i < 6; i++) begin
      rd(A1, d);
      chk("coherent_read", d, {7'b0, exp6[i]});
    end
`else
    wait_done();
    chk("deb_scan1", pad1_state, 8'h00);
    btn1 = 8'h02;
    wait_done();
    chk("deb_scan2", pad1_state, 8'h00);
    wait_done();
    chk("deb_scan3", pad1_state, 8'h02);
`endif
    random_ops(2500);
    begin
      int t = 0;
      while (p != SP + 3 * CD + 4 * CD * 2 - 2 * CD + 1 && t < 200) begin @(negedge clk); t++; end
      chk("bit4_clk_hi", pad_clk, 1'b1);
      rst = 1'b0;
      #1;
      chk("rst_pad_clk", pad_clk, 1'b0);
      chk("rst_pad_latch", pad_latch, 1'b0);
      chk("rst_pad1", pad1_state, 8'h00);
      chk("rst_pad2", pad2_state, 8'h00);
      chk("rst_done", scan_done, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!pad_latch && t < 100);
      chk("latch_after_rst", t, SP);
    end
    random_ops(1500);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/joycon_scan_ctrl.md
# joycon_scan_ctrl

Sequencer and CPU-side controller for both NES joypad ports. It periodically scans two physical serial NES pads by driving their latch and clock lines, and commits the button bytes into holding registers. It serves the CPU's $4016/$4017 strobe and serial-read protocol from those snapshots. It sits between the memory-mapped I/O decode and the board pad connectors, and replaces direct button wiring into the CPU register path.

## Interface
- CLK_DIV, 6: clk cycles per pad half-phase; minimum 3.
- SCAN_PERIOD, 50000: clk cycles spent in IDLE between scans.
- P1_ADDR, 16'h4016: strobe write and port-1 read address.
- P2_ADDR, 16'h4017: port-2 read address; writes to it are ignored.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- cpu_addr  in  16  CPU bus address
- cpu_data_in  in  8  CPU write data; only bit 0 is used
- cpu_write_en  in  1  one-cycle write strobe
- cpu_read_en  in  1  one-cycle read strobe
- cpu_data_out  out  8  read data, {7'b0, bit}
- pad_latch  out  1  pad latch line, active-high
- pad_clk  out  1  pad shift clock
- pad_data  in  2  serial pad data, [0]=port 1, [1]=port 2; active-low, asynchronous
- pad1_state  out  8  committed port-1 buttons, active-high
- pad2_state  out  8  committed port-2 buttons, active-high
- scan_done  out  1  one-cycle pulse when a scan commits

## Operation
- **Button order:** bit0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right.
- **Input sync:** pad_data passes through a 2-flop synchronizer. Bits are inverted on capture.
- **Scan FSM:** IDLE -> LATCH -> WAIT0 -> (CLK_HI -> CLK_LO) x7 -> COMMIT -> IDLE.
  - IDLE: counts SCAN_PERIOD cycles, then moves to LATCH.
  - LATCH: pad_latch=1 for 2*CLK_DIV cycles.
  - WAIT0: pad_latch=0 for CLK_DIV cycles; samples bit 0 on its last cycle.
  - CLK_HI: pad_clk=1 for CLK_DIV cycles.
  - CLK_LO: pad_clk=0 for CLK_DIV cycles; samples the next bit on its last cycle.
  - COMMIT: one cycle; writes the raw bytes to padN_state and pulses scan_done.
- **Strobe:** a write to P1_ADDR sets strobe <= cpu_data_in[0].
  - While strobe=1, both shift registers reload from padN_state every cycle.
  - The final reload happens in the cycle strobe goes 0; the CPU then reads that snapshot.
- **Read at P1_ADDR:** cpu_data_out <= {7'b0, sh1[0]}.
  - If strobe=0, sh1 <= {1'b1, sh1[7:1]}. After 8 reads, every further read returns 1.
  - If strobe=1, the read returns the live A bit and does not shift.
- **Read at P2_ADDR:** same behaviour using sh2.
- **Other addresses:** cpu_data_out holds its value.
- **Simultaneous events:**
  - COMMIT with strobe=0 leaves sh1/sh2 untouched, so an in-progress CPU read sequence stays coherent.
  - A write and a read at P1_ADDR in the same cycle: the write wins and no shift occurs.
- **Reset:** applies at any point, including mid-scan.
  - All outputs go to 0; strobe=0, sh1=sh2=8'h00; FSM goes to IDLE with its counter cleared.
  - Any partial scan is discarded.

## Timing
- First LATCH starts SCAN_PERIOD cycles after reset deasserts.
- Scan length is 17*CLK_DIV cycles, plus 1 COMMIT cycle. Default: 103 cycles.
- padN_state and scan_done update at the clock edge ending COMMIT.
- Sample points lag the pad line by 2 cycles of synchronizer delay. CLK_DIV>=3 guarantees the sampled data is stable.
- cpu_data_out is valid 1 cycle after the cpu_read_en cycle.
- A strobe write takes effect for reloads from the next cycle.
- pad_latch and pad_clk are registered outputs and never high simultaneously.

## Configuration
- **JOYCON_DEBOUNCE_EN defined:**
  - The FSM keeps the previous raw scan for each port.
  - COMMIT writes padN_state only if the raw byte equals the previous raw byte; otherwise padN_state holds.
  - scan_done pulses on every COMMIT regardless.
  - After reset, the first scan never commits, because the previous raw byte is invalid.
- **Not defined:** every COMMIT writes padN_state unconditionally.

## Test plan
- Use CLK_DIV=3 and SCAN_PERIOD=20 for all scenarios.
- Model pad 1 pressing A+Start (0x09) and pad 2 pressing Right (0x80); run one scan. Expect pad1_state=0x09 and pad2_state=0x80 at COMMIT, a single scan_done pulse, latch high 6 cycles, and 7 pad_clk pulses.
- After the above, write 1 then 0 to $4016, then read $4016 ten times. Expect 1,0,0,1,0,0,0,0,1,1.
- With strobe=1, read $4016 three times with A held. Expect 1,1,1 and sh1 not shifted.
- Read $4016 twice, then let COMMIT land with pad 1 changed to 0xFF; read six more times. Expect the remaining bits of the 0x09 snapshot: 0,1,0,0,0,0.
- Assert rst during CLK_HI of bit 4. Expect pad_clk=0, pad_latch=0, padN_state=0, no scan_done, and the next LATCH exactly 20 cycles after release.
- With JOYCON_DEBOUNCE_EN, present 0x01, then 0x02, then 0x02 on successive scans. Expect pad1_state 0x00, 0x00, 0x02.
